// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: ALU function codes, flag bit positions
// and branch type encodings.
package cpu_pkg;

  localparam int unsigned FUN_BITS  = 6;
  localparam int unsigned FLAG_BITS = 4;

  localparam logic [FUN_BITS-1:0] FUN_ADD  = 6'd2;
  localparam logic [FUN_BITS-1:0] FUN_SUB  = 6'd3;
  localparam logic [FUN_BITS-1:0] FUN_OR   = 6'd5;
  localparam logic [FUN_BITS-1:0] FUN_RLC  = 6'd6;
  localparam logic [FUN_BITS-1:0] FUN_RRC  = 6'd7;
  localparam logic [FUN_BITS-1:0] FUN_SETC = 6'd8;
  localparam logic [FUN_BITS-1:0] FUN_CLRC = 6'd9;
  localparam logic [FUN_BITS-1:0] FUN_NOT  = 6'd14;
  localparam logic [FUN_BITS-1:0] FUN_NEG  = 6'd15;
  localparam logic [FUN_BITS-1:0] FUN_INC  = 6'd16;
  localparam logic [FUN_BITS-1:0] FUN_DEC  = 6'd17;
  localparam logic [FUN_BITS-1:0] FUN_LOOP = 6'd22;

  localparam int unsigned FLG_V = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_Z = 0;

  typedef enum logic [2:0] {
    BR_JMP  = 3'd0,
    BR_JZ   = 3'd1,
    BR_JN   = 3'd2,
    BR_JC   = 3'd3,
    BR_JV   = 3'd4,
    BR_LOOP = 3'd5,
    BR_RSV6 = 3'd6,
    BR_RSV7 = 3'd7
  } br_type_e;

endpackage

// File: rtl/ccr_branch_unit_branch_resolver.sv
// Branch condition evaluation against the forwarded (effective) flags.
// clear_mask marks the flag a taken conditional branch consumes.
module branch_resolver
  import cpu_pkg::*;
(
  input  logic [FLAG_BITS-1:0] eff,
  input  logic                 br_valid,
  input  logic [2:0]           br_type,
  output logic                 br_taken,
  output logic [FLAG_BITS-1:0] clear_mask
);

  // Decode branch type and test the selected flag
  always_comb begin
    br_taken   = 1'b0;
    clear_mask = '0;
    if (br_valid) begin
      case (br_type_e'(br_type))
        BR_JMP:  br_taken = 1'b1;
        BR_JZ: begin
          br_taken          = eff[FLG_Z];
          clear_mask[FLG_Z] = eff[FLG_Z];
        end
        BR_JN: begin
          br_taken          = eff[FLG_N];
          clear_mask[FLG_N] = eff[FLG_N];
        end
        BR_JC: begin
          br_taken          = eff[FLG_C];
          clear_mask[FLG_C] = eff[FLG_C];
        end
        BR_JV: begin
          br_taken          = eff[FLG_V];
          clear_mask[FLG_V] = eff[FLG_V];
        end
        BR_LOOP: br_taken = ~eff[FLG_Z];
        default: br_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ccr_branch_unit.sv
// Condition-code register, ALU carry-in source, branch resolution on
// forwarded flags, and a one-entry interrupt shadow of the CCR.
module ccr_branch_unit
  import cpu_pkg::*;
#(
  parameter int FUN_W  = 6,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [FUN_W-1:0]  ex_alu_fun,
  input  logic [FLAG_W-1:0] ex_flags,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] ccr,
  output logic              alu_carry_in,
  output logic              br_taken,
  output logic              flush,
  output logic              shadow_valid
);

  logic [FLAG_W-1:0] mask;
  logic [FLAG_W-1:0] eff;
  logic [FLAG_W-1:0] clear_mask;
  logic [FLAG_W-1:0] shadow;
  logic              taken_raw;
  logic              restore;

  // Which flags the execute-stage ALU operation owns
  always_comb begin
    mask = '0;
    if (ex_valid) begin
      case (ex_alu_fun)
        FUN_ADD, FUN_SUB: mask = '1;
        FUN_OR, FUN_NOT, FUN_NEG, FUN_INC, FUN_DEC, FUN_LOOP: begin
          mask[FLG_N] = 1'b1;
          mask[FLG_Z] = 1'b1;
        end
        FUN_RLC, FUN_RRC, FUN_SETC, FUN_CLRC: mask[FLG_C] = 1'b1;
        default: mask = '0;
      endcase
    end
  end

  assign eff = (ex_flags & mask) | (ccr & ~mask);

  branch_resolver u_resolver (
    .eff        (eff),
    .br_valid   (br_valid),
    .br_type    (br_type),
    .br_taken   (taken_raw),
    .clear_mask (clear_mask)
  );

  assign br_taken     = taken_raw & ~reset;
  assign flush        = br_taken;
  assign alu_carry_in = ccr[FLG_C];
  assign restore      = rti_restore & shadow_valid;

  // CCR and shadow update: restore beats normal update; save sees the restored value
  always_ff @(posedge clk) begin
    if (reset) begin
      ccr          <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
    end else if (!stall) begin
      if (restore) begin
        ccr          <= shadow;
        shadow_valid <= 1'b0;
      end else begin
        ccr <= eff & ~clear_mask;
      end
      if (int_save) begin
        shadow       <= restore ? shadow : eff;
        shadow_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Self-checking bench for ccr_branch_unit: directed scenarios followed by
// randomized traffic, compared against a flag-level reference model.
module tb_ccr_branch_unit;

  logic       clk = 1'b0;
  logic       reset, stall, ex_valid, br_valid, int_save, rti_restore;
  logic [5:0] ex_alu_fun;
  logic [3:0] ex_flags;
  logic [2:0] br_type;
  logic [3:0] ccr;
  logic       alu_carry_in, br_taken, flush, shadow_valid;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [3:0] m_ccr, m_sh;
  logic       m_sv;

  ccr_branch_unit #(.FUN_W(6), .FLAG_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_alu_fun   (ex_alu_fun),
    .ex_flags     (ex_flags),
    .br_valid     (br_valid),
    .br_type      (br_type),
    .int_save     (int_save),
    .rti_restore  (rti_restore),
    .ccr          (ccr),
    .alu_carry_in (alu_carry_in),
    .br_taken     (br_taken),
    .flush        (flush),
    .shadow_valid (shadow_valid)
  );

  always #5 clk = ~clk;

  // flag ownership per function code; flag index 3=V 2=C 1=N 0=Z
  function automatic bit owns(input int fun, input int idx);
    if (fun == 2 || fun == 3) return 1'b1;
    if (fun inside {5, 14, 15, 16, 17, 22}) return idx <= 1;
    if (fun inside {6, 7, 8, 9}) return idx == 2;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_eff();
    logic [3:0] e;
    for (int i = 0; i < 4; i++)
      e[i] = (ex_valid && owns(int'(ex_alu_fun), i)) ? ex_flags[i] : m_ccr[i];
    return e;
  endfunction

  // JZ..JV test flag index (type-1); LOOP tests Z clear
  function automatic bit model_taken(input logic [3:0] e);
    int t = int'(br_type);
    if (!br_valid || reset) return 1'b0;
    if (t == 0) return 1'b1;
    if (t >= 1 && t <= 4) return e[t-1];
    if (t == 5) return !e[0];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; ex_valid = 0; ex_alu_fun = 0; ex_flags = 0;
    br_valid = 0; br_type = 0; int_save = 0; rti_restore = 0;
  endtask

  // Inputs already driven; check combinational outputs, clock, check state
  task automatic step();
    logic [3:0] e, n_ccr, n_sh;
    logic       tk, n_sv, rs;
    #1;
    e  = model_eff();
    tk = model_taken(e);
    chk("br_taken", {3'b0, br_taken}, {3'b0, tk});
    chk("flush", {3'b0, flush}, {3'b0, tk});
    n_ccr = m_ccr; n_sh = m_sh; n_sv = m_sv;
    if (reset) begin
      n_ccr = 0; n_sh = 0; n_sv = 0;
    end else if (!stall) begin
      rs = rti_restore && m_sv;
      if (rs) begin
        n_ccr = m_sh; n_sv = 0;
      end else begin
        n_ccr = e;
        if (tk && br_type >= 1 && br_type <= 4) n_ccr[br_type-1] = 1'b0;
      end
      if (int_save) begin
        n_sh = rs ? m_sh : e; n_sv = 1;
      end
    end
    @(posedge clk);
    m_ccr = n_ccr; m_sh = n_sh; m_sv = n_sv;
    #1;
    chk("ccr", ccr, m_ccr);
    chk("alu_carry_in", {3'b0, alu_carry_in}, {3'b0, m_ccr[2]});
    chk("shadow_valid", {3'b0, shadow_valid}, {3'b0, m_sv});
  endtask

  task automatic alu(input logic [5:0] f, input logic [3:0] fl);
    idle(); ex_valid = 1; ex_alu_fun = f; ex_flags = fl;
  endtask

  initial begin
    m_ccr = 'x; m_sh = 'x; m_sv = 'x;
    idle();
    @(posedge clk); #1;

    // reset with a JMP present: branch must be suppressed
    idle(); reset = 1; br_valid = 1; br_type = 0; step();
    chk("reset_ccr", ccr, 4'b0000);

    alu(2, 4'b1001); step();
    chk("add_ccr", ccr, 4'b1001);
    chk("add_carry", {3'b0, alu_carry_in}, 4'b0000);

    idle(); reset = 1; step();
    alu(8, 4'b0100); step();
    chk("setc_ccr", ccr, 4'b0100);
    alu(5, 4'b0110); step();
    chk("or_keeps_c", ccr, 4'b0110);

    // same-cycle SUB + JZ
    idle(); reset = 1; step();
    alu(3, 4'b0001); br_valid = 1; br_type = 1; #1;
    chk("jz_taken", {3'b0, br_taken}, 4'b0001);
    step();
    chk("jz_clears_z", ccr, 4'b0000);

    alu(22, 4'b0000); br_valid = 1; br_type = 5; step();
    alu(22, 4'b0001); br_valid = 1; br_type = 5; #1;
    chk("loop_z1_not_taken", {3'b0, br_taken}, 4'b0000);
    step();
    chk("loop_z1_ccr", ccr, 4'b0001);

    // interrupt save / restore
    idle(); reset = 1; step();
    alu(2, 4'b0101); step();
    idle(); int_save = 1; step();
    chk("save_valid", {3'b0, shadow_valid}, 4'b0001);
    alu(8, 4'b0100); step();
    alu(9, 4'b0000); step();
    alu(2, 4'b1111); rti_restore = 1; step();
    chk("restore_ccr", ccr, 4'b0101);
    chk("restore_valid", {3'b0, shadow_valid}, 4'b0000);

    // stall holds
    alu(2, 4'b1111); stall = 1; step();
    alu(2, 4'b1111); stall = 1; step();
    chk("stall_hold", ccr, 4'b0101);
    // restore without valid shadow is ignored
    alu(8, 4'b0100); rti_restore = 1; step();
    chk("rti_ignored_setc", {3'b0, ccr[2]}, 4'b0001);

    // simultaneous save and restore
    idle(); int_save = 1; step();
    alu(2, 4'b1010); step();
    alu(2, 4'b0011); int_save = 1; rti_restore = 1; step();
    chk("save_restore_ccr", ccr, 4'b0101);
    chk("save_restore_valid", {3'b0, shadow_valid}, 4'b0001);

    // reset mid-sequence
    idle(); reset = 1; step();
    chk("midreset_ccr", ccr, 4'b0000);
    chk("midreset_valid", {3'b0, shadow_valid}, 4'b0000);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned pick;
      idle();
      reset       = ($urandom_range(0, 39) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      ex_valid    = ($urandom_range(0, 4) != 0);
      pick        = $urandom_range(0, 15);
      ex_alu_fun  = (pick < 12) ? 6'(pick == 0 ? 2 : pick == 1 ? 3 : pick == 2 ? 5 :
                    pick == 3 ? 6 : pick == 4 ? 7 : pick == 5 ? 8 : pick == 6 ? 9 :
                    pick == 7 ? 14 : pick == 8 ? 15 : pick == 9 ? 16 : pick == 10 ? 17 : 22)
                    : 6'($urandom_range(0, 63));
      ex_flags    = 4'($urandom);
      br_valid    = ($urandom_range(0, 1) == 1);
      br_type     = 3'($urandom);
      int_save    = ($urandom_range(0, 7) == 0);
      rti_restore = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccr_branch_unit.md
Name: ccr_branch_unit

Overview:
- Execute-stage neighbour directly downstream of the ALU. Consumes the ALU's 4-bit flag vector and the ALU function code.
- Holds the architectural condition-code register (CCR) and supplies the carry-in the ALU needs for RLC/RRC.
- Resolves conditional branches and LOOP against forwarded flags.
- Saves and restores the CCR around interrupts through a one-entry shadow register.

Parameters:
- FUN_W, 6, width of the ALU function code.
- FLAG_W, 4, CCR width; bit order {V, C, N, Z}, V=bit3, Z=bit0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freezes the CCR, shadow and outputs. Branch resolution still evaluates.
- ex_valid  in  1  execute-stage instruction valid.
- ex_alu_fun  in  6  ALU function code of the execute-stage instruction.
- ex_flags  in  4  ALU flag output {V,C,N,Z}.
- br_valid  in  1  execute-stage instruction is a branch.
- br_type  in  3  0=JMP, 1=JZ, 2=JN, 3=JC, 4=JV, 5=LOOP; 6-7 are reserved.
- int_save  in  1  interrupt entry: copy the CCR to the shadow.
- rti_restore  in  1  return-from-interrupt: copy the shadow to the CCR.
- ccr  out  4  registered CCR.
- alu_carry_in  out  1  equals ccr[2]; feeds the ALU rotate logic.
- br_taken  out  1  combinational; branch taken this cycle.
- flush  out  1  combinational; equals br_taken, squashes the fetch and decode stages.
- shadow_valid  out  1  registered; the shadow holds a saved CCR.

Behaviour:
- Reset, sampled at the clock edge:
  - ccr=0, shadow=0, shadow_valid=0.
  - The same cycle also forces br_taken=0 and flush=0.
- Update mask is decoded from ex_alu_fun and applies only when ex_valid=1:
  - 2 ADD, 3 SUB: V, C, N, Z.
  - 5 OR, 14 NOT, 15 NEG, 16 INC, 17 DEC, 22 LOOP: N, Z.
  - 6 RLC, 7 RRC, 8 SETC, 9 CLRC: C.
  - Every other code: no update.
- Effective flags eff = (ex_flags & mask) | (ccr & ~mask). Branch resolution uses eff, so an ALU result and the branch that depends on it resolve in the same cycle with zero bubbles.
- Branch conditions (taken only when br_valid=1):
  - JMP: always.
  - JZ, JN, JC, JV: taken when eff Z, N, C, V respectively is 1.
  - LOOP: taken when eff Z=0.
  - Reserved types: never taken.
- A taken JZ, JN, JC or JV clears the tested flag in the next CCR value. JMP and LOOP do not modify the CCR.
- CCR next-state priority, highest first:
  1. reset.
  2. stall: hold.
  3. rti_restore with shadow_valid=1: ccr<=shadow, shadow_valid<=0. The same-cycle ALU update and branch clear are discarded.
  4. Otherwise ccr<=eff, then the taken-branch flag clear is applied to that value.
- rti_restore with shadow_valid=0 is ignored, and the normal update proceeds.
- Shadow register:
  - int_save (not stalled) does shadow<=eff, shadow_valid<=1, so it captures the instruction completing in the same cycle.
  - A second int_save while valid overwrites the shadow; there is no nesting.
  - int_save and rti_restore in the same cycle: the restore happens first, then the save captures the restored value. Final state: ccr=old shadow, shadow=old shadow, shadow_valid=1.
- Latency: a flag update becomes visible on ccr and alu_carry_in one cycle after ex_valid.
- alu_carry_in is always the registered C bit. It is not forwarded, and the pipeline guarantees this via its interlocks.
- stall=1: br_taken still reflects eff. The pipeline is responsible for not acting on it while stalled.
- All outputs are free of X after the first reset edge.

Decomposition:
- Shared package `cpu_pkg`:
  - ALU function codes: FUN_ADD=2, FUN_SUB=3, FUN_OR=5, FUN_RLC=6, FUN_RRC=7, FUN_SETC=8, FUN_CLRC=9, FUN_NOT=14, FUN_NEG=15, FUN_INC=16, FUN_DEC=17, FUN_LOOP=22.
  - Flag indices: FLG_V=3, FLG_C=2, FLG_N=1, FLG_Z=0.
  - br_type encodings.
  - The ALU should also import this package.
- One combinational sub-module, `branch_resolver`: inputs eff, br_valid and br_type; outputs br_taken and clear_mask.
- The mask decode, CCR, shadow and priority logic stay in the top module.

Test Plan:
- Reset, then ADD with ex_flags=4'b1001 (V=1, Z=1) -> ccr=4'b1001 next cycle; alu_carry_in=0.
- ccr=4'b0100, then OR with ex_flags=4'b0110 -> ccr=4'b0110. C is retained from the old CCR because OR does not own C.
- ccr=0; same cycle: SUB ex_flags=4'b0001 and br_valid, br_type=JZ -> br_taken=1, flush=1 that cycle; next ccr=4'b0000 (Z cleared).
- LOOP with ex_flags Z=0 -> br_taken=1. Then LOOP with ex_flags Z=1 -> br_taken=0, ccr Z=1.
- ccr=4'b0101, int_save -> shadow=4'b0101, shadow_valid=1. Then SETC, then CLRC, then rti_restore alongside an ADD with ex_flags=4'b1111 -> ccr=4'b0101, shadow_valid=0.
- Stall held for 2 cycles with an ADD ex_flags=4'b1111 -> ccr unchanged. rti_restore with shadow_valid=0 plus SETC -> ccr C=1. Synchronous reset mid-sequence -> ccr=0 and shadow_valid=0 at the next edge.
